// File: rtl/add_arb_pkg.sv
// Shared types and sizing helpers for the add_pipe_arbiter block.
// Holds the controller state encoding and the tag/counter width function.
package add_arb_pkg;

    localparam int ARB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int arb_tag_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_pipe_arbiter_if.sv
// Requester, shared-adder and response signals of add_pipe_arbiter.
// slave is the arbiter's view; master is the surrounding logic's view.
interface add_pipe_arbiter_if
    import add_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ARB_WIDTH
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  op_valid;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [WIDTH:0]        res_sum;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH:0]        rsp_sum;

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  res_sum,
        output req_ready,
        output op_valid,
        output op_a,
        output op_b,
        output rsp_valid,
        output rsp_sum
    );

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output res_sum,
        input  req_ready,
        input  op_valid,
        input  op_a,
        input  op_b,
        input  rsp_valid,
        input  rsp_sum
    );

endinterface

// File: rtl/add_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// i_ptr (wrapping), returned as one-hot, as an index and as an any flag.
module add_arb_rr_pick #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 2
) (
    input  logic [NREQ-1:0]  i_eligible,
    input  logic [TAG_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [TAG_W-1:0] o_idx,
    output logic             o_any
);

    int              w_cand;
    logic [NREQ-1:0] w_mask;

    // Walk ptr, ptr+1, ... mod NREQ and latch the first eligible slot.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        w_mask  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = int'(i_ptr) + k;
            w_cand = (w_cand >= NREQ) ? (w_cand - NREQ) : w_cand;
            w_mask = {{(NREQ-1){1'b0}}, 1'b1} << w_cand;
            if (!o_any && ((i_eligible & w_mask) != '0)) begin
                o_grant = w_mask;
                o_idx   = TAG_W'(w_cand);
                o_any   = 1'b1;
            end else begin
                o_any   = o_any;
            end
        end
    end

endmodule

// File: rtl/add_pipe_arbiter.sv
// Shares one fixed-latency registered adder among NREQ requesters: round-robin
// grant, one launch per cycle, tag pipeline routing each sum back to its owner.
module add_pipe_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ARB_WIDTH,
    parameter int LAT   = 3
) (
    input  logic              clki,
    input  logic              rst,
    input  logic              i_en,
    output logic              o_idle,
    add_pipe_arbiter_if.slave bus
);

    localparam int TAG_W = arb_tag_w(NREQ);
    localparam int CNT_W = arb_tag_w(NREQ + 1);

    arb_state_e                 r_state;
    arb_state_e                 w_state_nx;
    logic [TAG_W-1:0]           r_ptr;
    logic [NREQ-1:0]            r_busy;
    logic [CNT_W-1:0]           r_inflight;
    logic [CNT_W-1:0]           w_inflight_nx;
    logic                       r_idle;

    logic                       r_op_valid;
    logic [WIDTH-1:0]           r_op_a;
    logic [WIDTH-1:0]           r_op_b;
    logic [TAG_W-1:0]           r_op_tag;

    logic [LAT-1:0]             r_tp_vld;
    logic [LAT-1:0][TAG_W-1:0]  r_tp_tag;

    logic [NREQ-1:0]            r_rsp_valid;
    logic [WIDTH:0]             r_rsp_sum;

    logic [NREQ-1:0]            w_eligible;
    logic [NREQ-1:0]            w_gnt_oh;
    logic [TAG_W-1:0]           w_gnt_idx;
    logic                       w_gnt_any;
    logic                       w_run;
    logic                       w_hs;
    logic [TAG_W-1:0]           w_ptr_nx;
    logic                       w_ret_vld;
    logic [TAG_W-1:0]           w_ret_tag;
    logic [NREQ-1:0]            w_ret_oh;
    logic [WIDTH-1:0]           w_sel_a;
    logic [WIDTH-1:0]           w_sel_b;

    // A requester with an op still in the adder cannot be granted again.
    assign w_eligible = bus.req_valid & ~r_busy;

    add_arb_rr_pick #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_gnt_oh),
        .o_idx      (w_gnt_idx),
        .o_any      (w_gnt_any)
    );

    assign w_run         = (r_state == RUN);
    assign w_hs          = w_gnt_any & w_run;
    assign bus.req_ready = w_run ? w_gnt_oh : '0;
    assign w_ptr_nx      = (w_gnt_idx == TAG_W'(NREQ - 1)) ? '0 : (w_gnt_idx + TAG_W'(1));

    assign w_ret_vld = r_tp_vld[LAT-1];
    assign w_ret_tag = r_tp_tag[LAT-1];

    // Decode the tag leaving the pipe into a one-hot response/busy-clear vector.
    always_comb begin
        w_ret_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ret_oh[i] = w_ret_vld & (w_ret_tag == TAG_W'(i));
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_a = w_sel_a | (bus.req_a[i*WIDTH +: WIDTH] & {WIDTH{w_gnt_oh[i]}});
            w_sel_b = w_sel_b | (bus.req_b[i*WIDTH +: WIDTH] & {WIDTH{w_gnt_oh[i]}});
        end
    end

    // In-flight count: launch adds one, response removes one.
    always_comb begin
        case ({w_hs, w_ret_vld})
            2'b10:   w_inflight_nx = r_inflight + CNT_W'(1);
            2'b01:   w_inflight_nx = r_inflight - CNT_W'(1);
            default: w_inflight_nx = r_inflight;
        endcase
    end

    // Enable/drain controller; a grant in the cycle en falls still counts as in flight.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (i_en) w_state_nx = RUN;
                else      w_state_nx = IDLE;
            end
            RUN: begin
                if (i_en)                               w_state_nx = RUN;
                else if ((r_inflight != '0) || w_hs)    w_state_nx = DRAIN;
                else                                    w_state_nx = IDLE;
            end
            DRAIN: begin
                if (i_en)                    w_state_nx = RUN;
                else if (r_inflight == '0)   w_state_nx = IDLE;
                else                         w_state_nx = DRAIN;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Pointer, busy flags, in-flight count and registered idle flag.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_busy     <= '0;
            r_inflight <= '0;
            r_idle     <= 1'b1;
        end else begin
            r_busy     <= (r_busy & ~w_ret_oh) | (w_hs ? w_gnt_oh : '0);
            r_inflight <= w_inflight_nx;
            r_idle     <= (w_state_nx == IDLE) && (w_inflight_nx == '0);
            if (w_hs) begin
                r_ptr <= w_ptr_nx;
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

    // Launch register: operands hold their last value when nothing is launched.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_op_valid <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_tag   <= '0;
        end else begin
            r_op_valid <= w_hs;
            if (w_hs) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_tag <= w_gnt_idx;
            end else begin
                r_op_a   <= r_op_a;
                r_op_b   <= r_op_b;
                r_op_tag <= r_op_tag;
            end
        end
    end

    // Tag pipe runs in lockstep with the adder; its last stage lines up with res_sum.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_tp_vld <= '0;
            r_tp_tag <= '0;
        end else begin
            r_tp_vld[0] <= r_op_valid;
            r_tp_tag[0] <= r_op_tag;
            for (int s = 1; s < LAT; s++) begin
                r_tp_vld[s] <= r_tp_vld[s-1];
                r_tp_tag[s] <= r_tp_tag[s-1];
            end
        end
    end

    // Response register: capture the adder result only for a live tag.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
        end else begin
            r_rsp_valid <= w_ret_oh;
            if (w_ret_vld) begin
                r_rsp_sum <= bus.res_sum;
            end else begin
                r_rsp_sum <= r_rsp_sum;
            end
        end
    end

    assign bus.op_valid  = r_op_valid;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_rsp_sum;
    assign o_idle        = r_idle;

endmodule

// File: tb/tb_add_pipe_arbiter.sv
// Bench for add_pipe_arbiter: directed vector table, hand sequences for drain
// and reset, and random traffic checked against a transaction-level model.
module tb_add_pipe_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LAT   = 3;

    logic clki = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic idle;

    add_pipe_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    add_pipe_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clki   (clki),
        .rst    (rst),
        .i_en   (en),
        .o_idle (idle),
        .bus    (bus)
    );

    always #5 clki = ~clki;

    // Shared adder stand-in: LAT registered stages, never reset.
    logic [WIDTH:0] add_pipe [LAT];
    always @(posedge clki) begin
        add_pipe[0] <= {1'b0, bus.op_a} + {1'b0, bus.op_b};
        for (int s = 1; s < LAT; s++) add_pipe[s] <= add_pipe[s-1];
    end
    assign bus.res_sum = add_pipe[LAT-1];

    typedef struct {
        int             due;
        int             req;
        logic [WIDTH:0] sum;
    } pend_t;

    pend_t          pq[$];
    int             m_state;   // 0 idle, 1 run, 2 drain
    int             m_ptr;
    int             cyc = 0;
    logic           m_opv;
    logic [7:0]     m_opa, m_opb;
    logic [8:0]     m_rsum;
    int             total = 0;
    int             bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(input int i);
        foreach (pq[k]) if (pq[k].req == i && pq[k].due > cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_inflight();
        int n = 0;
        foreach (pq[k]) if (pq[k].due > cyc) n++;
        return n;
    endfunction

    task automatic model_reset();
        pq.delete();
        m_state = 0;
        m_ptr   = 0;
        m_opv   = 1'b0;
        m_opa   = '0;
        m_opb   = '0;
        m_rsum  = '0;
    endtask

    // One clock cycle: check DUT against the model, advance the model, move to next negedge.
    task automatic cycle();
        int         g;
        int         infl;
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        logic [7:0] ga, gb;
        pend_t      keep[$];
        #1;
        exp_rsp = '0;
        foreach (pq[k]) if (pq[k].due == cyc) begin
            exp_rsp = exp_rsp | (4'd1 << pq[k].req);
            m_rsum  = pq[k].sum;
        end
        g = -1;
        if (m_state == 1) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && ((bus.req_valid >> i) & 4'd1) != 4'd0 && !m_busy(i)) g = i;
            end
        end
        exp_ready = (g >= 0) ? (4'd1 << g) : 4'd0;
        infl = m_inflight();
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("op_valid",  32'(bus.op_valid),  32'(m_opv));
        chk("op_a",      32'(bus.op_a),      32'(m_opa));
        chk("op_b",      32'(bus.op_b),      32'(m_opb));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        chk("rsp_sum",   32'(bus.rsp_sum),   32'(m_rsum));
        chk("idle",      32'(idle),          32'(m_state == 0 && infl == 0));
        m_opv = (g >= 0);
        if (g >= 0) begin
            ga = 8'(bus.req_a >> (g * WIDTH));
            gb = 8'(bus.req_b >> (g * WIDTH));
            m_opa = ga;
            m_opb = gb;
            pq.push_back('{cyc + LAT + 2, g, {1'b0, ga} + {1'b0, gb}});
            m_ptr = (g + 1) % NREQ;
        end
        infl = m_inflight();
        case (m_state)
            0:       if (en) m_state = 1;
            1:       if (!en) m_state = (infl > 0) ? 2 : 0;
            2:       if (en) m_state = 1; else if (infl == 0) m_state = 0;
            default: m_state = 0;
        endcase
        foreach (pq[k]) if (pq[k].due > cyc) keep.push_back(pq[k]);
        pq = keep;
        cyc++;
        @(negedge clki);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_idle",      32'(idle),          32'd1);
        chk("rst_op_valid",  32'(bus.op_valid),  32'd0);
        @(negedge clki);
        @(negedge clki);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  rv;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rdy;
        logic        opv;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic [3:0]  rsp;
        logic [8:0]  sum;
        logic        idl;
    } vec_t;

    vec_t tbl [10];
    int   n;

    initial begin
        // Directly after reset: en rise, lone req2 (ptr skip), then req0+req3 with req3 winning.
        tbl[0] = '{1'b1, 4'b0100, 32'h00FF_0000, 32'h0001_0000, 4'b0000, 1'b0, 8'h00, 8'h00, 4'b0000, 9'h000, 1'b1};
        tbl[1] = '{1'b1, 4'b0100, 32'h00FF_0000, 32'h0001_0000, 4'b0100, 1'b0, 8'h00, 8'h00, 4'b0000, 9'h000, 1'b0};
        tbl[2] = '{1'b1, 4'b1001, 32'h1200_00AA, 32'h3400_00BB, 4'b1000, 1'b1, 8'hFF, 8'h01, 4'b0000, 9'h000, 1'b0};
        tbl[3] = '{1'b1, 4'b0001, 32'h0000_007F, 32'h0000_0080, 4'b0001, 1'b1, 8'h12, 8'h34, 4'b0000, 9'h000, 1'b0};
        tbl[4] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000, 1'b1, 8'h7F, 8'h80, 4'b0000, 9'h000, 1'b0};
        tbl[5] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000, 1'b0, 8'h7F, 8'h80, 4'b0000, 9'h000, 1'b0};
        tbl[6] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000, 1'b0, 8'h7F, 8'h80, 4'b0100, 9'h100, 1'b0};
        tbl[7] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000, 1'b0, 8'h7F, 8'h80, 4'b1000, 9'h046, 1'b0};
        tbl[8] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000, 1'b0, 8'h7F, 8'h80, 4'b0001, 9'h0FF, 1'b0};
        tbl[9] = '{1'b1, 4'b0000, 32'h0,         32'h0,         4'b0000, 1'b0, 8'h7F, 8'h80, 4'b0000, 9'h0FF, 1'b0};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        model_reset();
        @(negedge clki);
        @(negedge clki);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            en            = tbl[v].en;
            bus.req_valid = tbl[v].rv;
            bus.req_a     = tbl[v].a;
            bus.req_b     = tbl[v].b;
            #1;
            chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[v].rdy));
            chk("tbl_opv",   32'(bus.op_valid),  32'(tbl[v].opv));
            chk("tbl_opa",   32'(bus.op_a),      32'(tbl[v].opa));
            chk("tbl_opb",   32'(bus.op_b),      32'(tbl[v].opb));
            chk("tbl_rsp",   32'(bus.rsp_valid), 32'(tbl[v].rsp));
            chk("tbl_sum",   32'(bus.rsp_sum),   32'(tbl[v].sum));
            chk("tbl_idle",  32'(idle),          32'(tbl[v].idl));
            cycle();
        end

        // All four requesting continuously: round-robin, re-grant on response.
        en            = 1'b1;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            bus.req_a = $urandom;
            bus.req_b = $urandom;
            #1;
            chk("single_grant", 32'($countones(bus.req_ready) <= 1), 32'd1);
            cycle();
        end

        // Drain with ops in flight, then resume.
        en = 1'b0;
        cycle();
        n = 0;
        while (!idle && n < 40) begin
            #1;
            chk("drain_no_grant", 32'(bus.req_ready), 32'd0);
            cycle();
            n++;
        end
        chk("drain_idle", 32'(idle), 32'd1);
        en = 1'b1;
        cycle();
        #1;
        chk("resume_grant", 32'(bus.req_ready != 4'd0), 32'd1);
        cycle();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            en            = ($urandom_range(0, 7) != 0);
            bus.req_valid = 4'($urandom);
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            cycle();
        end

        // Reset with three ops in flight: nothing may come back afterwards.
        do_reset();
        en            = 1'b1;
        bus.req_valid = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            bus.req_a = $urandom;
            bus.req_b = $urandom;
            cycle();
        end
        bus.req_valid = '0;
        en            = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
            cycle();
        end
        chk("idle_after_reset", 32'(idle), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
